// File: rtl/crc8_frame_checker_if.sv
// Byte-stream link into the CRC-8 frame checker: one byte per in_valid cycle, no backpressure.
interface crc8_frame_checker_if;
  logic [7:0] in_data;
  logic       in_valid;

  modport master (output in_data, output in_valid);
  modport slave  (input  in_data, input  in_valid);
endinterface

// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 (poly 0x07, init 0x00, MSB-first) checker for LEN-prefixed frames,
// with per-frame pass/crc-error/timeout status and saturating good/bad frame counters.
module crc8_frame_checker #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  crc8_frame_checker_if.slave  rx,
  input  logic                 cnt_clr,
  output logic                 busy,
  output logic                 done,
  output logic                 ok,
  output logic                 crc_err,
  output logic                 timeout_err,
  output logic [7:0]           rx_crc,
  output logic [7:0]           calc_crc,
  output logic [CNT_W-1:0]     good_cnt,
  output logic [CNT_W-1:0]     bad_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PAYLOAD = 2'd1;
  localparam logic [1:0] CHECK   = 2'd2;

  localparam int               GAP_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [1:0]       state;
  logic [7:0]       remaining;
  logic [7:0]       crc;
  logic [GAP_W-1:0] gap;

  logic       check_hit;
  logic       timeout_hit;
  logic       crc_match;
  logic       fin_good;
  logic       fin_bad;
  logic [7:0] crc_next;

  always_comb begin
    crc_next    = crc8_update(crc, rx.in_data);
    crc_match   = (rx.in_data == crc);
    check_hit   = (state == CHECK) && rx.in_valid;
    // The abort fires on the edge that closes the last allowed idle cycle.
    timeout_hit = (state != IDLE) && !rx.in_valid && (gap == GAP_LAST);
    fin_good    = check_hit && crc_match;
    fin_bad     = (check_hit && !crc_match) || timeout_hit;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      remaining   <= 8'h00;
      crc         <= 8'h00;
      gap         <= '0;
      done        <= 1'b0;
      ok          <= 1'b0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
      rx_crc      <= 8'h00;
      calc_crc    <= 8'h00;
      good_cnt    <= '0;
      bad_cnt     <= '0;
    end else begin
      done <= check_hit || timeout_hit;

      case (state)
        IDLE: begin
          if (rx.in_valid) begin
            remaining <= rx.in_data;
            crc       <= 8'h00;
            gap       <= '0;
            state     <= (rx.in_data == 8'h00) ? CHECK : PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (rx.in_valid) begin
            crc       <= crc_next;
            remaining <= remaining - 8'd1;
            gap       <= '0;
            if (remaining == 8'd1) state <= CHECK;
          end else if (!timeout_hit) begin
            gap <= gap + GAP_ONE;
          end
        end
        CHECK: begin
          if (rx.in_valid) begin
            rx_crc      <= rx.in_data;
            calc_crc    <= crc;
            ok          <= crc_match;
            crc_err     <= !crc_match;
            timeout_err <= 1'b0;
            state       <= IDLE;
          end else if (!timeout_hit) begin
            gap <= gap + GAP_ONE;
          end
        end
        default: state <= IDLE;
      endcase

      if (timeout_hit) begin
        ok          <= 1'b0;
        crc_err     <= 1'b0;
        timeout_err <= 1'b1;
        rx_crc      <= 8'h00;
        calc_crc    <= crc;
        gap         <= '0;
        state       <= IDLE;
      end

      // A clear on the same edge as a frame conclusion takes precedence.
      if (cnt_clr) begin
        good_cnt <= '0;
        bad_cnt  <= '0;
      end else begin
        if (fin_good) good_cnt <= sat_inc(good_cnt);
        if (fin_bad)  bad_cnt  <= sat_inc(bad_cnt);
      end
    end
  end

endmodule
